// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   XLEN_DEFAULT / RESET_PC_DEFAULT : default address width and reset fetch address
//   INSTR_W                         : instruction word width (fixed at 32)
//   fetch_state_e                   : fetch FSM states (RUN, FAULT)
//   fetch_entry_t                   : one fetch buffer entry {pc, instr}
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_W          = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO with head/tail pointers and an occupancy count.
//   clk, rst    : clock, asynchronous active-low reset
//   flush       : synchronous clear, takes priority over push/pop
//   push, wdata : write wdata at the tail
//   pop         : advance the head
//   rdata       : head entry, read combinationally from storage
//   full, empty : occupancy flags
// The caller guarantees no push when full without a simultaneous pop, and no
// pop when empty. Push and pop together on a full buffer is legal: the tail
// slot equals the head slot, and the head moves past it at the same edge.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers are exactly PTR_W bits, so modulo-DEPTH wrap is free.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; slots outside [head, tail) are don't-care.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= wdata;
  end

  assign rdata = mem_q[head_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, RUN/FAULT FSM and a fetch buffer.
//   clk, rst                    : clock, asynchronous active-low reset
//   imem_addr / imem_rdata      : instruction memory request (combinational read)
//   redirect_valid, redirect_pc : branch/jump restart; misaligned target faults
//   id_ready                    : decode consumes the head entry
//   if_valid, if_instr, if_pc,
//   if_pc_plus4                 : head entry presented to decode
//   fetch_fault                 : misaligned redirect seen, fetch halted
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter int             FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            fetch_fault
);

  localparam int ENTRY_W = XLEN + INSTR_W;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             push, pop, full, empty;
  logic [ENTRY_W-1:0] head_entry;

  // Redirect wins over everything: it blocks both push and pop this cycle.
  // A push is still allowed on a full buffer when the head pops at the same edge.
  assign pop  = !empty && id_ready && !redirect_valid;
  assign push = (state_q == RUN) && !redirect_valid && (!full || pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
    end else if (push) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_q, imem_rdata}),
    .rdata (head_entry),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr   = pc_q;
  assign if_valid    = !empty;
  assign if_pc       = head_entry[ENTRY_W-1:INSTR_W];
  assign if_instr    = head_entry[INSTR_W-1:0];
  assign if_pc_plus4 = if_pc + XLEN'(4);
  assign fetch_fault = (state_q == FAULT);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 32, address/instruction width in bits.
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter FIFO_DEPTH, 4, fetch buffer entries; power of two, 2..16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 imem_addr  output  XLEN  fetch address, equal to the PC register.
REQ-007 imem_rdata  input  32  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump taken; flush and restart.
REQ-009 redirect_pc  input  XLEN  restart address, sampled when redirect_valid=1.
REQ-010 id_ready  input  1  decode accepts the head entry this cycle.
REQ-011 if_valid  output  1  head entry valid.
REQ-012 if_instr  output  32  head instruction.
REQ-013 if_pc  output  XLEN  head instruction address.
REQ-014 if_pc_plus4  output  XLEN  if_pc + 4, modulo 2^XLEN.
REQ-015 fetch_fault  output  1  misaligned redirect seen; fetch halted.

Function
REQ-016 FSM states: RUN and FAULT; reset state is RUN.
REQ-017 Pop occurs when if_valid=1 and id_ready=1 and redirect_valid=0.
REQ-018 Push occurs in RUN when redirect_valid=0 and (count<FIFO_DEPTH or pop). Push writes {PC, imem_rdata} at tail, and PC advances by 4.
REQ-019 Push and pop in the same cycle, including when full: both take effect; count unchanged.
REQ-020 No push when full without a pop; PC holds.
REQ-021 if_valid = (count != 0); if_instr/if_pc come from the head entry, with zero latency from the head register.
REQ-022 Fetch-to-if_valid latency: one cycle (written at edge N, visible after edge N).
REQ-023 redirect_valid=1 and redirect_pc[1:0]==0: count cleared, head=tail=0, PC<=redirect_pc, state RUN (also leaves FAULT). There is no push or pop that cycle.
REQ-024 redirect_valid=1 and redirect_pc[1:0]!=0: buffer flushed, PC<=redirect_pc, state<=FAULT, fetch_fault<=1.
REQ-025 In FAULT: no pushes. The buffer stays empty and PC holds. Exit is only via an aligned redirect.
REQ-026 Redirect has priority over pop and push in the same cycle.
REQ-027 PC increment wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000), with no fault.
REQ-028 Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.
REQ-029 Buffer entries do not need reset; data at invalid slots is don't-care.

Reset
REQ-030 rst=0 asynchronously forces: PC=RESET_PC, count=0, head=tail=0, state=RUN, fetch_fault=0, if_valid=0.
REQ-031 Reset asserted mid-operation discards all buffered entries. The first push after rst rises fetches RESET_PC.
REQ-032 Release is synchronous to clk. The first fetch occurs at the first rising edge with rst=1.

Structure
REQ-033 Shared package: XLEN and RESET_PC defaults, the fetch state enum (RUN, FAULT), and the buffer-entry struct {pc, instr}.
REQ-034 Single sub-module fetch_fifo, parametrised on width and FIFO_DEPTH, with synchronous flush, push, pop, full and empty. PC/FSM logic stays in fetch_unit.

Verification
REQ-035 Reset, id_ready=1, imem returns addr^32'hA5A5_0000 -> if_pc sequence 0,4,8,...; if_valid=1 from the second cycle after release.
REQ-036 id_ready=0 for 6 cycles (DEPTH=4) -> count saturates at 4 and PC=16 held. Then id_ready=1 -> pops pc 0,4,8,12,16 back-to-back with no bubble.
REQ-037 Full buffer with redirect_valid=1, redirect_pc=32'h100, and id_ready=1 in the same cycle -> next cycle if_valid=0. After that, if_pc=32'h100 and if_pc_plus4=32'h104; entries 0..12 are never seen.
REQ-038 redirect_pc=32'h102 -> fetch_fault=1, if_valid stays 0 for 10 cycles. Then redirect_pc=32'h200 -> fetch_fault=0 and if_pc=32'h200.
REQ-039 RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc_plus4 of FFFF_FFFC = 0.
REQ-040 rst pulsed low asynchronously mid-cycle with 3 entries buffered -> if_valid=0 immediately. After release, first if_pc=RESET_PC.
